// File: rtl/nios2_ocimem_arbiter.sv
// OCI debug RAM sequencer: shares one registered single-port RAM between the
// JTAG debug command path and the CPU-side Avalon slave, round-robin arbitrated.
module nios2_ocimem_arbiter #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  jtag_set_addr,
    input  logic [ADDR_W-1:0]     jtag_addr,
    input  logic                  jtag_access,
    input  logic                  jtag_wr,
    input  logic [DATA_W-1:0]     jtag_wdata,
    output logic [DATA_W-1:0]     mon_dreg,
    output logic                  mon_ready,
    output logic                  jtag_overrun,
    input  logic                  avs_read,
    input  logic                  avs_write,
    input  logic [ADDR_W-1:0]     avs_address,
    input  logic [DATA_W-1:0]     avs_writedata,
    input  logic [DATA_W/8-1:0]   avs_byteenable,
    output logic                  avs_waitrequest,
    output logic [DATA_W-1:0]     avs_readdata,
    output logic [ADDR_W-1:0]     ram_addr,
    output logic [DATA_W-1:0]     ram_wdata,
    output logic [DATA_W/8-1:0]   ram_be,
    output logic                  ram_we,
    output logic                  ram_re,
    input  logic [DATA_W-1:0]     ram_rdata
);

    localparam int BE_W = DATA_W / 8;

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_ISSUE   = 2'd1;
    localparam logic [1:0] S_CAPTURE = 2'd2;
    localparam logic [1:0] S_RESP    = 2'd3;

    localparam logic GNT_AVS  = 1'b0;
    localparam logic GNT_JTAG = 1'b1;

    logic [1:0]        state_q, state_d;
    logic              gnt_q, gnt_d;
    logic              op_wr_q, op_wr_d;
    logic              last_grant_q, last_grant_d;
    logic              jtag_pend_q, jtag_pend_d;
    logic              jtag_wr_q, jtag_wr_d;
    logic [DATA_W-1:0] jtag_wdata_q, jtag_wdata_d;
    logic [ADDR_W-1:0] jaddr_q, jaddr_d;
    logic              overrun_q, overrun_d;
    logic [DATA_W-1:0] mon_dreg_q, mon_dreg_d;
    logic              mon_ready_q, mon_ready_d;
    logic              waitreq_q, waitreq_d;
    logic [DATA_W-1:0] readdata_q, readdata_d;
    logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
    logic [DATA_W-1:0] ram_wdata_q, ram_wdata_d;
    logic [BE_W-1:0]   ram_be_q, ram_be_d;
    logic              ram_we_q, ram_we_d;
    logic              ram_re_q, ram_re_d;

    logic              set_ok, acc_ok, jtag_req, avs_req, pick_jtag, grant_wr;
    logic              jwr_now;
    logic [DATA_W-1:0] jwdata_now;
    logic [ADDR_W-1:0] jaddr_now;

    // jtag_pend stays set from acceptance through RESP, so it also marks a grant in flight.
    assign set_ok     = jtag_set_addr && !jtag_pend_q;
    assign acc_ok     = jtag_access && !jtag_pend_q;
    assign jaddr_now  = set_ok ? jtag_addr : jaddr_q;
    assign jtag_req   = jtag_pend_q || acc_ok;
    assign jwr_now    = jtag_pend_q ? jtag_wr_q : jtag_wr;
    assign jwdata_now = jtag_pend_q ? jtag_wdata_q : jtag_wdata;
    assign avs_req    = avs_read || avs_write;

    always_comb begin
        state_d      = state_q;
        gnt_d        = gnt_q;
        op_wr_d      = op_wr_q;
        last_grant_d = last_grant_q;
        jtag_pend_d  = jtag_pend_q;
        jtag_wr_d    = jtag_wr_q;
        jtag_wdata_d = jtag_wdata_q;
        jaddr_d      = jaddr_q;
        overrun_d    = overrun_q;
        mon_dreg_d   = mon_dreg_q;
        mon_ready_d  = 1'b0;
        waitreq_d    = 1'b1;
        readdata_d   = readdata_q;
        ram_addr_d   = ram_addr_q;
        ram_wdata_d  = ram_wdata_q;
        ram_be_d     = ram_be_q;
        ram_we_d     = 1'b0;
        ram_re_d     = 1'b0;
        pick_jtag    = 1'b0;
        grant_wr     = 1'b0;

        if ((jtag_access || jtag_set_addr) && jtag_pend_q) begin
            overrun_d = 1'b1;
        end
        if (set_ok) begin
            jaddr_d = jtag_addr;
        end
        if (acc_ok) begin
            jtag_pend_d  = 1'b1;
            jtag_wr_d    = jtag_wr;
            jtag_wdata_d = jtag_wdata;
        end

        case (state_q)
            S_IDLE: begin
                if (jtag_req || avs_req) begin
                    pick_jtag    = jtag_req && (!avs_req || (last_grant_q == GNT_AVS));
                    gnt_d        = pick_jtag ? GNT_JTAG : GNT_AVS;
                    last_grant_d = gnt_d;
                    state_d      = S_ISSUE;
                    if (pick_jtag) begin
                        grant_wr    = jwr_now;
                        ram_addr_d  = jaddr_now;
                        ram_wdata_d = jwdata_now;
                        ram_be_d    = '1;
                    end else begin
                        grant_wr    = avs_write;
                        ram_addr_d  = avs_address;
                        ram_wdata_d = avs_writedata;
                        ram_be_d    = avs_byteenable;
                    end
                    op_wr_d  = grant_wr;
                    ram_we_d = grant_wr;
                    ram_re_d = !grant_wr;
                end
            end
            S_ISSUE: begin
                if (op_wr_q) begin
                    state_d = S_RESP;
                    if (gnt_q == GNT_JTAG) begin
                        mon_dreg_d  = ram_wdata_q;
                        mon_ready_d = 1'b1;
                    end else begin
                        waitreq_d = 1'b0;
                    end
                end else begin
                    state_d = S_CAPTURE;
                end
            end
            S_CAPTURE: begin
                // RAM data is valid now, one cycle after ram_re.
                state_d = S_RESP;
                if (gnt_q == GNT_JTAG) begin
                    mon_dreg_d  = ram_rdata;
                    mon_ready_d = 1'b1;
                end else begin
                    readdata_d = ram_rdata;
                    waitreq_d  = 1'b0;
                end
            end
            default: begin
                state_d = S_IDLE;
                if (gnt_q == GNT_JTAG) begin
                    jaddr_d     = jaddr_q + 1'b1;
                    jtag_pend_d = 1'b0;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= S_IDLE;
            gnt_q        <= GNT_AVS;
            op_wr_q      <= 1'b0;
            last_grant_q <= GNT_AVS;
            jtag_pend_q  <= 1'b0;
            jtag_wr_q    <= 1'b0;
            jtag_wdata_q <= '0;
            jaddr_q      <= '0;
            overrun_q    <= 1'b0;
            mon_dreg_q   <= '0;
            mon_ready_q  <= 1'b0;
            waitreq_q    <= 1'b1;
            readdata_q   <= '0;
            ram_addr_q   <= '0;
            ram_wdata_q  <= '0;
            ram_be_q     <= '0;
            ram_we_q     <= 1'b0;
            ram_re_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            gnt_q        <= gnt_d;
            op_wr_q      <= op_wr_d;
            last_grant_q <= last_grant_d;
            jtag_pend_q  <= jtag_pend_d;
            jtag_wr_q    <= jtag_wr_d;
            jtag_wdata_q <= jtag_wdata_d;
            jaddr_q      <= jaddr_d;
            overrun_q    <= overrun_d;
            mon_dreg_q   <= mon_dreg_d;
            mon_ready_q  <= mon_ready_d;
            waitreq_q    <= waitreq_d;
            readdata_q   <= readdata_d;
            ram_addr_q   <= ram_addr_d;
            ram_wdata_q  <= ram_wdata_d;
            ram_be_q     <= ram_be_d;
            ram_we_q     <= ram_we_d;
            ram_re_q     <= ram_re_d;
        end
    end

    assign mon_dreg        = mon_dreg_q;
    assign mon_ready       = mon_ready_q;
    assign jtag_overrun    = overrun_q;
    assign avs_waitrequest = waitreq_q;
    assign avs_readdata    = readdata_q;
    assign ram_addr        = ram_addr_q;
    assign ram_wdata       = ram_wdata_q;
    assign ram_be          = ram_be_q;
    assign ram_we          = ram_we_q;
    assign ram_re          = ram_re_q;

endmodule

// File: tb/tb_nios2_ocimem_arbiter.sv
// Directed bench for nios2_ocimem_arbiter with a behavioural OCI RAM attached.
module tb_nios2_ocimem_arbiter;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        jtag_set_addr = 1'b0;
    logic [7:0]  jtag_addr = '0;
    logic        jtag_access = 1'b0;
    logic        jtag_wr = 1'b0;
    logic [31:0] jtag_wdata = '0;
    logic [31:0] mon_dreg;
    logic        mon_ready;
    logic        jtag_overrun;
    logic        avs_read = 1'b0;
    logic        avs_write = 1'b0;
    logic [7:0]  avs_address = '0;
    logic [31:0] avs_writedata = '0;
    logic [3:0]  avs_byteenable = 4'hF;
    logic        avs_waitrequest;
    logic [31:0] avs_readdata;
    logic [7:0]  ram_addr;
    logic [31:0] ram_wdata;
    logic [3:0]  ram_be;
    logic        ram_we;
    logic        ram_re;
    logic [31:0] ram_rdata = '0;

    logic [31:0] mem [0:255];
    int total = 0;
    int bad = 0;
    int acc_cnt = 0;
    int mon_cnt = 0;
    int acc0, mon0;

    nios2_ocimem_arbiter #(.ADDR_W(8), .DATA_W(32)) dut (
        .clk(clk), .reset_n(reset_n),
        .jtag_set_addr(jtag_set_addr), .jtag_addr(jtag_addr),
        .jtag_access(jtag_access), .jtag_wr(jtag_wr), .jtag_wdata(jtag_wdata),
        .mon_dreg(mon_dreg), .mon_ready(mon_ready), .jtag_overrun(jtag_overrun),
        .avs_read(avs_read), .avs_write(avs_write), .avs_address(avs_address),
        .avs_writedata(avs_writedata), .avs_byteenable(avs_byteenable),
        .avs_waitrequest(avs_waitrequest), .avs_readdata(avs_readdata),
        .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_be(ram_be),
        .ram_we(ram_we), .ram_re(ram_re), .ram_rdata(ram_rdata)
    );

    always #5 clk = ~clk;

    // Single-port RAM: byte-enabled write, read data one cycle after ram_re.
    always @(posedge clk) begin
        if (ram_we) begin
            for (int b = 0; b < 4; b++) begin
                if (ram_be[b]) mem[ram_addr][b*8 +: 8] <= ram_wdata[b*8 +: 8];
            end
        end
        if (ram_re) ram_rdata <= mem[ram_addr];
    end

    always @(negedge clk) begin
        if (ram_we || ram_re) acc_cnt <= acc_cnt + 1;
        if (mon_ready) mon_cnt <= mon_cnt + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        total++;
        assert (obs === exp_v) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp_v);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tick();
        tick();
        chk("rst_waitreq", 32'(avs_waitrequest), 32'd1);
        chk("rst_we", 32'(ram_we), 32'd0);
        chk("rst_re", 32'(ram_re), 32'd0);
        chk("rst_monrdy", 32'(mon_ready), 32'd0);
        chk("rst_mondreg", mon_dreg, 32'd0);
        chk("rst_readdata", avs_readdata, 32'd0);
        chk("rst_ramaddr", 32'(ram_addr), 32'd0);
        chk("rst_rambe", 32'(ram_be), 32'd0);
        chk("rst_overrun", 32'(jtag_overrun), 32'd0);
        reset_n = 1'b1;
        tick();

        // JTAG write 0xDEADBEEF to 0x10
        jtag_set_addr = 1'b1; jtag_addr = 8'h10;
        tick();
        jtag_set_addr = 1'b0;
        jtag_access = 1'b1; jtag_wr = 1'b1; jtag_wdata = 32'hDEADBEEF;
        tick();
        jtag_access = 1'b0;
        chk("jw_we", 32'(ram_we), 32'd1);
        chk("jw_re", 32'(ram_re), 32'd0);
        chk("jw_addr", 32'(ram_addr), 32'h10);
        chk("jw_be", 32'(ram_be), 32'hF);
        chk("jw_wdata", ram_wdata, 32'hDEADBEEF);
        chk("jw_rdy_early", 32'(mon_ready), 32'd0);
        tick();
        chk("jw_rdy", 32'(mon_ready), 32'd1);
        chk("jw_dreg", mon_dreg, 32'hDEADBEEF);
        tick();
        chk("jw_rdy_pulse", 32'(mon_ready), 32'd0);

        // second write with no set_addr: address must have auto-incremented
        jtag_access = 1'b1; jtag_wr = 1'b1; jtag_wdata = 32'h11111111;
        tick();
        jtag_access = 1'b0;
        chk("jinc_addr", 32'(ram_addr), 32'h11);
        chk("jinc_we", 32'(ram_we), 32'd1);
        tick();
        tick();

        // readback: set_addr and access in the same cycle use the new address
        jtag_set_addr = 1'b1; jtag_addr = 8'h10;
        jtag_access = 1'b1; jtag_wr = 1'b0;
        tick();
        jtag_set_addr = 1'b0; jtag_access = 1'b0;
        chk("jr_re", 32'(ram_re), 32'd1);
        chk("jr_addr", 32'(ram_addr), 32'h10);
        tick();
        chk("jr_rdy_early", 32'(mon_ready), 32'd0);
        tick();
        chk("jr_rdy", 32'(mon_ready), 32'd1);
        chk("jr_dreg", mon_dreg, 32'hDEADBEEF);
        tick();
        chk("jr_rdy_pulse", 32'(mon_ready), 32'd0);

        // Avalon read of 0x10
        avs_read = 1'b1; avs_address = 8'h10; avs_byteenable = 4'h3;
        tick();
        chk("ar_re", 32'(ram_re), 32'd1);
        chk("ar_be", 32'(ram_be), 32'h3);
        chk("ar_wait1", 32'(avs_waitrequest), 32'd1);
        tick();
        chk("ar_wait2", 32'(avs_waitrequest), 32'd1);
        tick();
        chk("ar_wait3", 32'(avs_waitrequest), 32'd0);
        chk("ar_data", avs_readdata, 32'hDEADBEEF);
        avs_read = 1'b0; avs_byteenable = 4'hF;
        tick();
        chk("ar_wait4", 32'(avs_waitrequest), 32'd1);

        // collision, last grant Avalon: JTAG read of 0x11 first, then Avalon write 0x20
        avs_write = 1'b1; avs_address = 8'h20; avs_writedata = 32'hCAFEF00D;
        jtag_access = 1'b1; jtag_wr = 1'b0;
        tick();
        jtag_access = 1'b0;
        chk("c1_jre", 32'(ram_re), 32'd1);
        chk("c1_jaddr", 32'(ram_addr), 32'h11);
        tick();
        tick();
        chk("c1_jrdy", 32'(mon_ready), 32'd1);
        chk("c1_jdreg", mon_dreg, 32'h11111111);
        chk("c1_wait_hold", 32'(avs_waitrequest), 32'd1);
        tick();
        tick();
        chk("c1_awe", 32'(ram_we), 32'd1);
        chk("c1_aaddr", 32'(ram_addr), 32'h20);
        chk("c1_awdata", ram_wdata, 32'hCAFEF00D);
        tick();
        chk("c1_await", 32'(avs_waitrequest), 32'd0);
        avs_write = 1'b0;
        tick();
        chk("c1_await_end", 32'(avs_waitrequest), 32'd1);

        // JTAG write at 0xFF so the address wraps and last grant becomes JTAG
        jtag_set_addr = 1'b1; jtag_addr = 8'hFF;
        jtag_access = 1'b1; jtag_wr = 1'b1; jtag_wdata = 32'h0BADF00D;
        tick();
        jtag_set_addr = 1'b0; jtag_access = 1'b0;
        chk("wrap_addr_ff", 32'(ram_addr), 32'hFF);
        tick();
        tick();

        // collision, last grant JTAG: Avalon read of 0x20 first, JTAG read at wrapped 0x00 after
        avs_read = 1'b1; avs_address = 8'h20;
        jtag_access = 1'b1; jtag_wr = 1'b0;
        tick();
        jtag_access = 1'b0;
        chk("c2_aaddr", 32'(ram_addr), 32'h20);
        chk("c2_are", 32'(ram_re), 32'd1);
        tick();
        tick();
        chk("c2_await", 32'(avs_waitrequest), 32'd0);
        chk("c2_adata", avs_readdata, 32'hCAFEF00D);
        chk("c2_no_jrdy", 32'(mon_ready), 32'd0);
        avs_read = 1'b0;
        tick();
        tick();
        chk("wrap_addr_00", 32'(ram_addr), 32'h00);
        chk("c2_jre", 32'(ram_re), 32'd1);
        tick();
        tick();
        chk("c2_jrdy", 32'(mon_ready), 32'd1);
        chk("c2_no_overrun", 32'(jtag_overrun), 32'd0);
        tick();

        // overrun: two back-to-back jtag_access pulses
        acc0 = acc_cnt; mon0 = mon_cnt;
        jtag_access = 1'b1; jtag_wr = 1'b1; jtag_wdata = 32'h55AA55AA;
        tick();
        jtag_wdata = 32'h12345678;
        tick();
        jtag_access = 1'b0;
        chk("ov_flag", 32'(jtag_overrun), 32'd1);
        chk("ov_rdy", 32'(mon_ready), 32'd1);
        chk("ov_dreg", mon_dreg, 32'h55AA55AA);
        tick();
        tick();
        tick();
        tick();
        chk("ov_accesses", 32'(acc_cnt - acc0), 32'd1);
        chk("ov_readies", 32'(mon_cnt - mon0), 32'd1);
        chk("ov_sticky", 32'(jtag_overrun), 32'd1);

        // reset during a read's CAPTURE cycle
        jtag_set_addr = 1'b1; jtag_addr = 8'h10;
        jtag_access = 1'b1; jtag_wr = 1'b0;
        tick();
        jtag_set_addr = 1'b0; jtag_access = 1'b0;
        chk("rr_issue", 32'(ram_re), 32'd1);
        tick();
        mon0 = mon_cnt;
        #2;
        reset_n = 1'b0;
        #1;
        chk("rr_waitreq", 32'(avs_waitrequest), 32'd1);
        chk("rr_re", 32'(ram_re), 32'd0);
        chk("rr_dreg", mon_dreg, 32'd0);
        chk("rr_overrun", 32'(jtag_overrun), 32'd0);
        chk("rr_ramaddr", 32'(ram_addr), 32'd0);
        tick();
        tick();
        chk("rr_no_rdy", 32'(mon_cnt - mon0), 32'd0);
        chk("rr_rdy_low", 32'(mon_ready), 32'd0);
        reset_n = 1'b1;
        tick();
        jtag_set_addr = 1'b1; jtag_addr = 8'h10;
        jtag_access = 1'b1; jtag_wr = 1'b0;
        tick();
        jtag_set_addr = 1'b0; jtag_access = 1'b0;
        chk("rr2_re", 32'(ram_re), 32'd1);
        chk("rr2_addr", 32'(ram_addr), 32'h10);
        tick();
        tick();
        chk("rr2_rdy", 32'(mon_ready), 32'd1);
        chk("rr2_dreg", mon_dreg, 32'hDEADBEEF);
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
